// File: rtl/bag_sched_pkg.sv
// ============================================================================
//  Module   : bag_pkg
//  Brief    : Shared bag codes, address/length defaults and FSM encodings
//             for the bag scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bag_pkg;

  // Bag type codes presented to the bag builder
  localparam logic [3:0] BAG_DLINK = 4'b1000;
  localparam logic [3:0] BAG_DTYPE = 4'b1001;
  localparam logic [3:0] BAG_DTEMP = 4'b1010;
  localparam logic [3:0] BAG_DATA0 = 4'b1101;
  localparam logic [3:0] BAG_DATA1 = 4'b1110;

  localparam logic [11:0] c_HALF0_ADDR = 12'h000;
  localparam logic [11:0] c_HALF1_ADDR = 12'h800;
  localparam logic [11:0] c_DATA_BLEN  = 12'd514;
  localparam logic [11:0] c_CTRL_BLEN  = 12'd2;
  localparam logic [15:0] c_TMO_CYC    = 16'd2048;

  typedef enum logic [2:0] {
    M_IDLE = 3'd0,
    M_ARB  = 3'd1,
    M_WORK = 3'd2,
    M_REL  = 3'd3,
    M_HOLD = 3'd4
  } mk_state_e;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_BUSY = 2'd1,
    T_REL  = 2'd2
  } tx_state_e;

  // RAM base of a ping-pong half
  function automatic logic [11:0] half_base(input logic half,
                                            input logic [11:0] base0,
                                            input logic [11:0] base1);
    return half ? base1 : base0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bag_sched_if.sv
// ============================================================================
//  Module   : bag_sched_if
//  Brief    : Request, bag-builder and transmitter handshake bundle of the
//             bag scheduler. master = scheduler side, slave = environment.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bag_sched_if;

  logic [3:0]  req;
  logic [3:0]  req_ack;
  logic        mk_fs;
  logic        mk_fd;
  logic [3:0]  mk_btype;
  logic [11:0] mk_addr;
  logic        tx_fs;
  logic        tx_fd;
  logic [11:0] tx_addr;
  logic [11:0] tx_len;
  logic        err;

  modport master (
    input  req, mk_fd, tx_fd,
    output req_ack, mk_fs, mk_btype, mk_addr, tx_fs, tx_addr, tx_len, err
  );

  modport slave (
    output req, mk_fd, tx_fd,
    input  req_ack, mk_fs, mk_btype, mk_addr, tx_fs, tx_addr, tx_len, err
  );

endinterface

`default_nettype wire

// File: rtl/bag_prio_arb.sv
// ============================================================================
//  Module   : bag_prio_arb
//  Brief    : Combinational fixed-priority arbiter DLINK > DTYPE > DTEMP >
//             DATA; returns a one-hot grant and the bag type to build.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bag_prio_arb
  import bag_pkg::*;
(
  input  logic [3:0] req,
  input  logic       data_tog,
  output logic [3:0] grant,
  output logic [3:0] btype,
  output logic       valid
);

  always_comb begin
    grant = 4'b0000;
    btype = BAG_DATA0;
    valid = |req;
    if (req[3]) begin
      grant = 4'b1000;
      btype = BAG_DLINK;
    end else if (req[2]) begin
      grant = 4'b0100;
      btype = BAG_DTYPE;
    end else if (req[1]) begin
      grant = 4'b0010;
      btype = BAG_DTEMP;
    end else if (req[0]) begin
      grant = 4'b0001;
      btype = data_tog ? BAG_DATA1 : BAG_DATA0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bag_sched.sv
// ============================================================================
//  Module   : bag_sched
//  Brief    : Bag build/transmit scheduler with ping-pong RAM halves and
//             DATA0/DATA1 alternation. Optional fd watchdog enabled by
//             defining BAG_SCHED_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bag_sched
  import bag_pkg::*;
#(
  parameter logic [11:0] HALF0_ADDR = c_HALF0_ADDR,
  parameter logic [11:0] HALF1_ADDR = c_HALF1_ADDR,
  parameter logic [11:0] DATA_BLEN  = c_DATA_BLEN,
  parameter logic [11:0] CTRL_BLEN  = c_CTRL_BLEN,
  parameter logic [15:0] TMO_CYC    = c_TMO_CYC
) (
  input  logic        clk,
  input  logic        rst_n,
  bag_sched_if.master bus
);

  mk_state_e   r_mstate, w_mstate_nxt;
  tx_state_e   r_tstate, w_tstate_nxt;

  logic [3:0]  r_grant;
  logic [3:0]  r_btype;
  logic [11:0] r_mk_addr;
  logic [11:0] r_tx_addr;
  logic [11:0] r_tx_len;
  logic [3:0]  r_req_ack;
  logic        r_half;
  logic        r_dtog;

  logic [3:0]  w_grant;
  logic [3:0]  w_btype;
  logic        w_valid;
  logic        w_latch;
  logic        w_handoff;
  logic        w_tx_idle;
  logic        w_tmo;

  bag_prio_arb u_arb (
    .req      (bus.req),
    .data_tog (r_dtog),
    .grant    (w_grant),
    .btype    (w_btype),
    .valid    (w_valid)
  );

  assign w_tx_idle = (r_tstate == T_IDLE);

  // ---------------------------------------------------------------- make FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mstate <= M_IDLE;
    end else begin
      r_mstate <= w_mstate_nxt;
    end
  end

  always_comb begin
    w_mstate_nxt = r_mstate;
    w_latch      = 1'b0;
    w_handoff    = 1'b0;
    bus.mk_fs    = (r_mstate == M_WORK);
    case (r_mstate)
      M_IDLE: w_mstate_nxt = M_ARB;
      M_ARB: begin
        if (w_valid) begin
          w_latch      = 1'b1;
          w_mstate_nxt = M_WORK;
        end
      end
      M_WORK: begin
        // a late fd still wins over a watchdog expiring in the same cycle
        if (bus.mk_fd) begin
          w_mstate_nxt = M_REL;
        end else if (w_tmo) begin
          w_mstate_nxt = M_ARB;
        end
      end
      M_REL: begin
        if (!bus.mk_fd) begin
          if (w_tx_idle) begin
            w_handoff    = 1'b1;
            w_mstate_nxt = M_ARB;
          end else begin
            w_mstate_nxt = M_HOLD;
          end
        end
      end
      M_HOLD: begin
        if (w_tx_idle) begin
          w_handoff    = 1'b1;
          w_mstate_nxt = M_ARB;
        end
      end
      default: w_mstate_nxt = M_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ tx FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tstate <= T_IDLE;
    end else begin
      r_tstate <= w_tstate_nxt;
    end
  end

  always_comb begin
    w_tstate_nxt = r_tstate;
    bus.tx_fs    = (r_tstate == T_BUSY);
    case (r_tstate)
      T_IDLE:  if (w_handoff)  w_tstate_nxt = T_BUSY;
      T_BUSY:  if (bus.tx_fd)  w_tstate_nxt = T_REL;
      T_REL:   if (!bus.tx_fd) w_tstate_nxt = T_IDLE;
      default: w_tstate_nxt = T_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant   <= 4'b0000;
      r_btype   <= 4'b0000;
      r_mk_addr <= HALF0_ADDR;
      r_tx_addr <= HALF0_ADDR;
      r_tx_len  <= 12'd0;
      r_req_ack <= 4'b0000;
      r_half    <= 1'b0;
      r_dtog    <= 1'b0;
    end else begin
      r_req_ack <= w_handoff ? r_grant : 4'b0000;
      if (w_latch) begin
        r_grant   <= w_grant;
        r_btype   <= w_btype;
        r_mk_addr <= half_base(r_half, HALF0_ADDR, HALF1_ADDR);
      end
      // r_mk_addr still holds the half just built, which is the one to send
      if (w_handoff) begin
        r_tx_addr <= r_mk_addr;
        r_tx_len  <= r_grant[0] ? DATA_BLEN : CTRL_BLEN;
        r_half    <= ~r_half;
        if (r_grant[0]) begin
          r_dtog <= ~r_dtog;
        end
      end
    end
  end

  assign bus.mk_btype = r_btype;
  assign bus.mk_addr  = r_mk_addr;
  assign bus.tx_addr  = r_tx_addr;
  assign bus.tx_len   = r_tx_len;
  assign bus.req_ack  = r_req_ack;

  // ---------------------------------------------------------------- watchdog
`ifdef BAG_SCHED_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;
  logic        r_err;

  assign w_tmo = (r_mstate == M_WORK) && (r_tmo_cnt == (TMO_CYC - 16'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= 16'd0;
      r_err     <= 1'b0;
    end else begin
      if (w_latch) begin
        r_tmo_cnt <= 16'd0;
      end else if (r_mstate == M_WORK) begin
        r_tmo_cnt <= r_tmo_cnt + 16'd1;
      end
      if (w_tmo && !bus.mk_fd) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.err = r_err;
`else
  logic w_unused_tmo;

  assign w_unused_tmo = ^TMO_CYC;
  assign w_tmo        = 1'b0;
  assign bus.err      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bag_sched.sv
// ============================================================================
//  Module   : tb_bag_sched
//  Brief    : Self-checking bench for bag_sched with builder, transmitter
//             and requester responders plus a served-bag reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bag_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bag_sched_if bus ();

  bag_sched #(
    .HALF0_ADDR (12'h000),
    .HALF1_ADDR (12'h800),
    .DATA_BLEN  (12'd514),
    .CTRL_BLEN  (12'd2),
    .TMO_CYC    (16'd16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int mk_dly = 10;
  int tx_dly = 20;
  int mk_cnt = 0;
  int tx_cnt = 0;
  bit drop_mode = 1'b0;
  int held_n = 1;
  int ack_seen = 0;

  logic [15:0] obs_mk[$], exp_mk[$];
  logic [23:0] obs_tx[$], exp_tx[$];
  logic [3:0]  obs_ack[$], exp_ack[$];

  logic        p_mk = 1'b0;
  logic        p_tx = 1'b0;
  logic [15:0] mk_hold = 16'd0;
  logic [23:0] tx_hold = 24'd0;

  // model: which half is next and whether the next DATA bag is DATA1
  bit m_half = 1'b0;
  bit m_dtog = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // bag builder: raise fd mk_dly cycles into fs, release it once fs drops
  initial begin
    bus.mk_fd = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.mk_fd = 1'b0;
        mk_cnt    = 0;
      end else if (bus.mk_fs && !bus.mk_fd) begin
        mk_cnt++;
        if (mk_cnt >= mk_dly) bus.mk_fd = 1'b1;
      end else if (!bus.mk_fs) begin
        bus.mk_fd = 1'b0;
        mk_cnt    = 0;
      end
    end
  end

  // transmitter
  initial begin
    bus.tx_fd = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.tx_fd = 1'b0;
        tx_cnt    = 0;
      end else if (bus.tx_fs && !bus.tx_fd) begin
        tx_cnt++;
        if (tx_cnt >= tx_dly) bus.tx_fd = 1'b1;
      end else if (!bus.tx_fs) begin
        bus.tx_fd = 1'b0;
        tx_cnt    = 0;
      end
    end
  end

  // requesters: drop the served bit, or drop everything after held_n acks
  initial begin
    bus.req = 4'd0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.req_ack != 4'd0) begin
        ack_seen++;
        if (drop_mode) bus.req = bus.req & ~bus.req_ack;
        else if (ack_seen >= held_n) bus.req = 4'd0;
      end
    end
  end

  // monitor: record starts and acks, hold fields stable during a transfer
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.mk_fs && !p_mk) begin
          mk_hold = {bus.mk_btype, bus.mk_addr};
          obs_mk.push_back(mk_hold);
        end else if (bus.mk_fs) begin
          check("mk_stable", {bus.mk_btype, bus.mk_addr}, mk_hold);
        end
        if (bus.tx_fs && !p_tx) begin
          tx_hold = {bus.tx_addr, bus.tx_len};
          obs_tx.push_back(tx_hold);
        end else if (bus.tx_fs || bus.tx_fd) begin
          check("tx_stable", {bus.tx_addr, bus.tx_len}, tx_hold);
        end
        if (bus.req_ack != 4'd0) obs_ack.push_back(bus.req_ack);
      end
      p_mk = bus.mk_fs;
      p_tx = bus.tx_fs;
    end
  end

  function automatic int top_bit(input logic [3:0] r);
    for (int i = 3; i >= 0; i--) if (r[i]) return i;
    return -1;
  endfunction

  task automatic model_bag(input int w);
    logic [3:0]  bt;
    logic [11:0] addr;
    logic [11:0] len;
    logic [3:0]  one;
    case (w)
      3:       bt = 4'b1000;
      2:       bt = 4'b1001;
      1:       bt = 4'b1010;
      default: bt = m_dtog ? 4'b1110 : 4'b1101;
    endcase
    addr = m_half ? 12'h800 : 12'h000;
    len  = (w == 0) ? 12'd514 : 12'd2;
    one  = 4'd0;
    one[w] = 1'b1;
    exp_mk.push_back({bt, addr});
    exp_tx.push_back({addr, len});
    exp_ack.push_back(one);
    m_half = !m_half;
    if (w == 0) m_dtog = !m_dtog;
  endtask

  task automatic clear_obs();
    obs_mk.delete();
    obs_tx.delete();
    obs_ack.delete();
    exp_mk.delete();
    exp_tx.delete();
    exp_ack.delete();
  endtask

  task automatic start_bags(input logic [3:0] r, input bit drop, input int n,
                            input int md, input int td);
    logic [3:0] bits;
    clear_obs();
    mk_dly    = md;
    tx_dly    = td;
    drop_mode = drop;
    held_n    = n;
    ack_seen  = 0;
    bits      = r;
    if (drop) begin
      while (bits != 4'd0) begin
        model_bag(top_bit(bits));
        bits[top_bit(bits)] = 1'b0;
      end
    end else begin
      for (int k = 0; k < n; k++) model_bag(top_bit(r));
    end
    @(negedge clk);
    bus.req = r;
  endtask

  task automatic finish_bags(input string tag);
    int budget;
    budget = 20000;
    while (budget > 0 && !(bus.req == 4'd0 && obs_tx.size() >= exp_tx.size() &&
                           !bus.tx_fs && !bus.tx_fd && !bus.mk_fs)) begin
      @(negedge clk);
      budget--;
    end
    repeat (5) @(negedge clk);
    check({tag, "_done"}, 32'(budget > 0), 32'd1);
    check({tag, "_nmk"}, obs_mk.size(), exp_mk.size());
    check({tag, "_ntx"}, obs_tx.size(), exp_tx.size());
    check({tag, "_nack"}, obs_ack.size(), exp_ack.size());
    for (int i = 0; i < exp_mk.size(); i++) begin
      if (i < obs_mk.size())  check({tag, "_mk"}, obs_mk[i], exp_mk[i]);
      if (i < obs_tx.size())  check({tag, "_tx"}, obs_tx[i], exp_tx[i]);
      if (i < obs_ack.size()) check({tag, "_ack"}, obs_ack[i], exp_ack[i]);
    end
  endtask

  initial begin
    int budget;
    int cnt;

    repeat (3) @(negedge clk);
    check("rst_mk_fs", bus.mk_fs, 1'b0);
    check("rst_tx_fs", bus.tx_fs, 1'b0);
    check("rst_ack", bus.req_ack, 4'd0);
    check("rst_btype", bus.mk_btype, 4'd0);
    check("rst_mk_addr", bus.mk_addr, 12'h000);
    check("rst_tx_addr", bus.tx_addr, 12'h000);
    check("rst_tx_len", bus.tx_len, 12'd0);
    check("rst_err", bus.err, 1'b0);
    rst_n = 1'b1;

    start_bags(4'b0001, 1'b0, 1, 10, 20);
    finish_bags("data0");
    start_bags(4'b0001, 1'b0, 1, 10, 20);
    finish_bags("data1");
    start_bags(4'b1111, 1'b1, 0, 4, 6);
    finish_bags("prio");
    start_bags(4'b1111, 1'b0, 2, 3, 5);
    finish_bags("dlink_again");

    // long transmit: the second bag must wait in hold without a new tx start
    start_bags(4'b0011, 1'b1, 0, 10, 1000);
    budget = 5000;
    while (budget > 0 && obs_tx.size() < 1) begin
      @(negedge clk);
      budget--;
    end
    repeat (200) @(negedge clk);
    check("hold_mk_fs", bus.mk_fs, 1'b0);
    check("hold_ntx", obs_tx.size(), 1);
    check("hold_nmk", obs_mk.size(), 2);
    check("hold_nack", obs_ack.size(), 1);
    finish_bags("hold");

    for (int k = 0; k < 8; k++) begin
      start_bags(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
                 $urandom_range(1, 3), $urandom_range(1, 12), $urandom_range(1, 25));
      finish_bags("rand");
    end

    // leave both half pointer and data toggle at 1 before resetting
    for (int k = 0; k < 4 && !(m_half && m_dtog); k++) begin
      start_bags(4'b0001, 1'b0, 1, 3, 3);
      finish_bags("pre_rst");
    end

    clear_obs();
    mk_dly    = 50;
    tx_dly    = 5;
    drop_mode = 1'b1;
    ack_seen  = 0;
    @(negedge clk);
    bus.req = 4'b0001;
    budget = 1000;
    while (budget > 0 && !bus.mk_fs) begin
      @(negedge clk);
      budget--;
    end
    check("rst_wait", 32'(budget > 0), 32'd1);
    repeat (5) @(negedge clk);
    rst_n   = 1'b0;
    bus.req = 4'd0;
    #1;
    check("mid_rst_mk_fs", bus.mk_fs, 1'b0);
    check("mid_rst_tx_fs", bus.tx_fs, 1'b0);
    check("mid_rst_ack", bus.req_ack, 4'd0);
    check("mid_rst_mk_addr", bus.mk_addr, 12'h000);
    check("mid_rst_btype", bus.mk_btype, 4'd0);
    repeat (2) @(negedge clk);
    m_half = 1'b0;
    m_dtog = 1'b0;
    rst_n  = 1'b1;
    start_bags(4'b0001, 1'b0, 1, 5, 5);
    finish_bags("post_rst");

`ifdef BAG_SCHED_TIMEOUT_EN
    clear_obs();
    mk_dly    = 100000;
    tx_dly    = 5;
    drop_mode = 1'b1;
    ack_seen  = 0;
    @(negedge clk);
    bus.req = 4'b0001;
    budget = 1000;
    while (budget > 0 && !bus.mk_fs) begin
      @(negedge clk);
      budget--;
    end
    cnt = 0;
    while (bus.mk_fs && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    bus.req = 4'd0;
    check("tmo_len", cnt, 16);
    check("tmo_err", bus.err, 1'b1);
    repeat (5) @(negedge clk);
    check("tmo_nack", obs_ack.size(), 0);
    start_bags(4'b0001, 1'b0, 1, 5, 5);
    finish_bags("post_tmo");
    check("tmo_err_sticky", bus.err, 1'b1);
`else
    check("err_tied", bus.err, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
